// File: rtl/lsu_data_memory.sv
// Byte-addressed MEM-stage data memory with a byte, half or word access size.
// Requests and responses use valid/ready handshakes, with a configurable access latency and an error counter.
module lsu_data_memory #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_BYTES = 128,
  parameter int LATENCY     = 1,
  parameter int ERRCNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [31:0]         req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [31:0]         rsp_rdata,
  output logic                rsp_err,
  output logic                busy,
  output logic [ERRCNT_W-1:0] err_count
);

  localparam int AW = $clog2(DEPTH_BYTES);
  localparam logic [1:0] LAT_M1 = 2'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [1:0]            r_cnt;
  logic                  r_write;
  logic [1:0]            r_size;
  logic                  r_unsigned;
  logic [ADDR_W-1:0]     r_addr;
  logic [31:0]           r_wdata;
  logic [7:0]            r_mem [DEPTH_BYTES];
  logic [31:0]           r_rdata;
  logic                  r_err;
  logic [ERRCNT_W-1:0]   r_errcnt;

  logic                  w_accept;
  logic                  w_access;
  logic                  w_done;
  logic                  w_oob;
  logic                  w_misalign;
  logic                  w_err;
  logic                  w_wr_en;
  logic [AW-1:0]         w_idx0;
  logic [AW-1:0]         w_idx1;
  logic [AW-1:0]         w_idx2;
  logic [AW-1:0]         w_idx3;
  logic [7:0]            w_b0;
  logic [7:0]            w_b1;
  logic [7:0]            w_b2;
  logic [7:0]            w_b3;
  logic [31:0]           w_load;
  logic                  w_req_ready;
  logic                  w_rsp_valid;
  logic                  w_busy;

  assign w_accept = (r_state == S_IDLE) && req_valid;
  assign w_access = (r_state == S_WAIT) && (r_cnt == 2'd0);
  assign w_done   = (r_state == S_RESP) && rsp_ready;
  assign w_oob    = |(r_addr >> AW);
  assign w_err    = w_misalign | w_oob;
  assign w_wr_en  = w_access && r_write && !w_err;

  // Only aligned accesses reach the array, so neighbour bytes never wrap
  assign w_idx0 = r_addr[AW-1:0];
  assign w_idx1 = {w_idx0[AW-1:1], 1'b1};
  assign w_idx2 = {w_idx0[AW-1:2], 2'b10};
  assign w_idx3 = {w_idx0[AW-1:2], 2'b11};
  assign w_b0   = r_mem[w_idx0];
  assign w_b1   = r_mem[w_idx1];
  assign w_b2   = r_mem[w_idx2];
  assign w_b3   = r_mem[w_idx3];

  always_comb begin
    w_misalign = 1'b0;
    case (r_size)
      2'b00:   w_misalign = 1'b0;
      2'b01:   w_misalign = r_addr[0];
      2'b10:   w_misalign = |r_addr[1:0];
      default: w_misalign = 1'b1;
    endcase
  end

  always_comb begin
    w_load = 32'd0;
    case (r_size)
      2'b00:   w_load = {{24{~r_unsigned & w_b0[7]}}, w_b0};
      2'b01:   w_load = {{16{~r_unsigned & w_b1[7]}}, w_b1, w_b0};
      default: w_load = {w_b3, w_b2, w_b1, w_b0};
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_WAIT; else w_next = S_IDLE;
      S_WAIT:  if (w_access) w_next = S_RESP; else w_next = S_WAIT;
      S_RESP:  if (rsp_ready) w_next = S_IDLE; else w_next = S_RESP;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_req_ready = 1'b0;
    w_rsp_valid = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      S_IDLE:  begin w_req_ready = reset; w_busy = 1'b0; end
      S_WAIT:  w_busy = 1'b1;
      S_RESP:  w_rsp_valid = 1'b1;
      default: w_busy = 1'b1;
    endcase
  end

  assign req_ready = w_req_ready;
  assign rsp_valid = w_rsp_valid;
  assign busy      = w_busy;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
  assign err_count = r_errcnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt      <= 2'd0;
      r_write    <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_addr     <= {ADDR_W{1'b0}};
      r_wdata    <= 32'd0;
    end else if (w_accept) begin
      r_cnt      <= LAT_M1;
      r_write    <= req_write;
      r_size     <= req_size;
      r_unsigned <= req_unsigned;
      r_addr     <= req_addr;
      r_wdata    <= req_wdata;
    end else if ((r_state == S_WAIT) && (r_cnt != 2'd0)) begin
      r_cnt <= r_cnt - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdata  <= 32'd0;
      r_err    <= 1'b0;
      r_errcnt <= {ERRCNT_W{1'b0}};
    end else if (w_access) begin
      r_rdata <= (w_err || r_write) ? 32'd0 : w_load;
      r_err   <= w_err;
      if (w_err && (r_errcnt != {ERRCNT_W{1'b1}}))
        r_errcnt <= r_errcnt + {{(ERRCNT_W-1){1'b0}}, 1'b1};
    end else if (w_done) begin
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end
  end

  // Array is intentionally left unreset; writes only land on an error-free access edge
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      case (r_size)
        2'b00: r_mem[w_idx0] <= r_wdata[7:0];
        2'b01: begin
          r_mem[w_idx0] <= r_wdata[7:0];
          r_mem[w_idx1] <= r_wdata[15:8];
        end
        2'b10: begin
          r_mem[w_idx0] <= r_wdata[7:0];
          r_mem[w_idx1] <= r_wdata[15:8];
          r_mem[w_idx2] <= r_wdata[23:16];
          r_mem[w_idx3] <= r_wdata[31:24];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_data_memory.sv
// Directed bench: four instances cover latency 1/4/3 and a 2-bit saturating error counter.
module tb_lsu_data_memory;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rsp_ready = 1'b1;
  logic        req_write = 1'b0;
  logic        req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [3:0]  v_in = 4'b0000;
  logic [3:0]  rdy;
  logic [3:0]  vld;
  logic [3:0]  er;
  logic [3:0]  bsy;
  logic [31:0] rdata [4];
  logic [15:0] ecnt0;
  logic [15:0] ecnt1;
  logic [15:0] ecnt2;
  logic [1:0]  ecnt_sat;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] rd;
  logic        e;
  int          lat;

  always #5 clk = ~clk;

  lsu_data_memory #(.LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .req_valid(v_in[0]), .req_ready(rdy[0]), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(vld[0]), .rsp_ready(rsp_ready), .rsp_rdata(rdata[0]), .rsp_err(er[0]),
    .busy(bsy[0]), .err_count(ecnt0));

  lsu_data_memory #(.LATENCY(4)) u_l4 (
    .clk(clk), .reset(reset), .req_valid(v_in[1]), .req_ready(rdy[1]), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(vld[1]), .rsp_ready(rsp_ready), .rsp_rdata(rdata[1]), .rsp_err(er[1]),
    .busy(bsy[1]), .err_count(ecnt1));

  lsu_data_memory #(.LATENCY(3)) u_l3 (
    .clk(clk), .reset(reset), .req_valid(v_in[2]), .req_ready(rdy[2]), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(vld[2]), .rsp_ready(rsp_ready), .rsp_rdata(rdata[2]), .rsp_err(er[2]),
    .busy(bsy[2]), .err_count(ecnt2));

  lsu_data_memory #(.LATENCY(1), .ERRCNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .req_valid(v_in[3]), .req_ready(rdy[3]), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(vld[3]), .rsp_ready(rsp_ready), .rsp_rdata(rdata[3]), .rsp_err(er[3]),
    .busy(bsy[3]), .err_count(ecnt_sat));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
    end
  endtask

  // Present a request for one cycle; on return we sit in the first cycle after acceptance
  task automatic issue(input int k, input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd);
    chk1("ready_before_accept", rdy[k], 1'b1);
    req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
    v_in[k] = 1'b1;
    tick();
    v_in[k] = 1'b0;
    chk1("ready_low_wait", rdy[k], 1'b0);
    chk1("busy_wait", bsy[k], 1'b1);
  endtask

  task automatic wait_rsp(input int k, input int start, output logic [31:0] r,
                          output logic ee, output int l);
    l = start;
    while (vld[k] !== 1'b1 && l < 40) begin
      tick();
      l++;
    end
    r  = rdata[k];
    ee = er[k];
    chk1("ready_low_resp", rdy[k], 1'b0);
  endtask

  task automatic run(input string tag, input int k, input logic w, input logic [1:0] sz,
                     input logic u, input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_e, input int exp_lat);
    logic [31:0] r;
    logic        ee;
    int          l;
    rsp_ready = 1'b1;
    issue(k, w, sz, u, a, wd);
    wait_rsp(k, 1, r, ee, l);
    chk({tag, "_latency"}, l, exp_lat);
    chk({tag, "_rdata"}, r, exp_rd);
    chk1({tag, "_err"}, ee, exp_e);
    tick();
    chk1({tag, "_valid_drop"}, vld[k], 1'b0);
    chk1({tag, "_ready_back"}, rdy[k], 1'b1);
    chk({tag, "_rdata_cleared"}, rdata[k], 32'd0);
  endtask

  initial begin
    #1 reset = 1'b0;
    #2;
    for (int k = 0; k < 4; k++) begin
      chk1("rst_ready", rdy[k], 1'b0);
      chk1("rst_valid", vld[k], 1'b0);
      chk1("rst_busy", bsy[k], 1'b0);
      chk1("rst_err", er[k], 1'b0);
      chk("rst_rdata", rdata[k], 32'd0);
    end
    chk("rst_errcnt", {16'd0, ecnt0}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) chk1("ready_after_reset", rdy[k], 1'b1);
    tick();

    // Latency 1: word/byte/half stores and loads
    run("st_w",   0, 1'b1, 2'b10, 1'b0, 32'h14, 32'hDEADBEEF, 32'h0,        1'b0, 2);
    run("ld_w",   0, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0,        32'hDEADBEEF, 1'b0, 2);
    run("st_b",   0, 1'b1, 2'b00, 1'b0, 32'h15, 32'h12345680, 32'h0,        1'b0, 2);
    run("ld_w2",  0, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0,        32'hDEAD80EF, 1'b0, 2);
    run("ld_bs",  0, 1'b0, 2'b00, 1'b0, 32'h15, 32'h0,        32'hFFFFFF80, 1'b0, 2);
    run("ld_bu",  0, 1'b0, 2'b00, 1'b1, 32'h15, 32'h0,        32'h00000080, 1'b0, 2);
    run("ld_hs",  0, 1'b0, 2'b01, 1'b0, 32'h16, 32'h0,        32'hFFFFDEAD, 1'b0, 2);
    run("ld_hu",  0, 1'b0, 2'b01, 1'b1, 32'h14, 32'h0,        32'h000080EF, 1'b0, 2);
    run("st_h",   0, 1'b1, 2'b01, 1'b0, 32'h14, 32'hAAAA1234, 32'h0,        1'b0, 2);
    run("ld_w3",  0, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0,        32'hDEAD1234, 1'b0, 2);

    // Error cases
    run("e_ldw16", 0, 1'b0, 2'b10, 1'b0, 32'h16, 32'h0,        32'h0,        1'b1, 2);
    run("st_w20",  0, 1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D, 32'h0,        1'b0, 2);
    run("e_sth21", 0, 1'b1, 2'b01, 1'b0, 32'h21, 32'h0000BBBB, 32'h0,        1'b1, 2);
    run("ld_w20",  0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0,        32'hCAFEF00D, 1'b0, 2);
    run("e_oob",   0, 1'b0, 2'b10, 1'b0, 32'h80, 32'h0,        32'h0,        1'b1, 2);
    run("e_sz11",  0, 1'b0, 2'b11, 1'b0, 32'h00, 32'h0,        32'h0,        1'b1, 2);
    chk("errcnt_four", {16'd0, ecnt0}, 32'd4);

    // Latency 4 with a stalled consumer and a stray request during WAIT
    run("l4_st", 1, 1'b1, 2'b10, 1'b0, 32'h00, 32'h01020304, 32'h0, 1'b0, 5);
    rsp_ready = 1'b0;
    issue(1, 1'b0, 2'b10, 1'b0, 32'h00, 32'h0);
    req_addr = 32'h04;
    v_in[1] = 1'b1;
    tick();
    v_in[1] = 1'b0;
    wait_rsp(1, 2, rd, e, lat);
    chk("l4_latency", lat, 32'd5);
    chk("l4_rdata", rd, 32'h01020304);
    chk1("l4_err", e, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1("l4_hold_valid", vld[1], 1'b1);
      chk("l4_hold_rdata", rdata[1], 32'h01020304);
    end
    rsp_ready = 1'b1;
    tick();
    chk1("l4_idle_busy", bsy[1], 1'b0);
    chk1("l4_idle_ready", rdy[1], 1'b1);
    chk1("l4_idle_valid", vld[1], 1'b0);
    repeat (6) tick();
    chk1("l4_stray_valid", vld[1], 1'b0);
    chk1("l4_stray_busy", bsy[1], 1'b0);
    chk("l4_errcnt", {16'd0, ecnt1}, 32'd0);

    // Latency 3: reset lands between accept and access, store must be lost
    run("l3_pre", 2, 1'b1, 2'b10, 1'b0, 32'h08, 32'hA5A5A5A5, 32'h0, 1'b0, 4);
    issue(2, 1'b1, 2'b10, 1'b0, 32'h08, 32'h12345678);
    tick();
    reset = 1'b0;
    #1;
    chk1("l3_rst_ready", rdy[2], 1'b0);
    chk1("l3_rst_valid", vld[2], 1'b0);
    chk1("l3_rst_busy", bsy[2], 1'b0);
    chk1("l3_rst_err", er[2], 1'b0);
    chk("l3_rst_rdata", rdata[2], 32'd0);
    tick();
    reset = 1'b1;
    tick();
    run("l3_ld", 2, 1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 32'hA5A5A5A5, 1'b0, 4);
    chk("l3_errcnt", {16'd0, ecnt2}, 32'd0);

    // 2-bit error counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      run("sat_ld", 3, 1'b0, 2'b10, 1'b0, 32'h01, 32'h0, 32'h0, 1'b1, 2);
      chk("sat_count", {30'd0, ecnt_sat}, (i < 3) ? 32'(i + 1) : 32'd3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
